fetch_stage: RTL and testbench

Instruction-fetch stage of the sMIPS pipeline. It holds the program counter, drives the address into the combinational instruction memory (`imem`), and registers the returned word into the IF/ID pipeline register for decode. It handles:

- pipeline stalls,
- branch/jump redirects resolved in ID, with the MIPS delay slot preserved,
- exception flushes,
- a misaligned-fetch flag.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings:
// control from ID/exception logic, the imem port and the IF/ID register.
interface fetch_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic        ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_adel_o;

  modport master (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, imem_inst_i,
    output imem_addr_o, ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o
  );

  modport slave (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, imem_inst_i,
    input  imem_addr_o, ce_o, id_pc_o, id_inst_o, id_valid_o, id_adel_o
  );
endinterface

// File: rtl/fetch_stage.sv
// sMIPS instruction fetch: PC, delay-slot-preserving redirects, stall with
// pending branch capture, exception flush and IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fs
);

  typedef enum logic {INIT, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= INIT;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      id_pc_q       <= 32'h0;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
      id_adel_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_valid_q    <= id_valid_d;
      id_adel_q     <= id_adel_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_valid_d    = id_valid_q;
    id_adel_d     = id_adel_q;

    case (state_q)
      INIT: begin
        // PC holds so RESET_PC is the first address fetched with ce_o high
        state_d    = RUN;
        id_pc_d    = 32'h0;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
        id_adel_d  = 1'b0;
      end
      default: begin
        if (fs.flush_i) begin
          pc_d         = fs.new_pc_i;
          pend_valid_d = 1'b0;
          id_pc_d      = 32'h0;
          id_inst_d    = NOP_INST;
          id_valid_d   = 1'b0;
          id_adel_d    = 1'b0;
        end else if (fs.stall_i) begin
          // remember a branch resolved while frozen; last one wins
          if (fs.branch_flag_i) begin
            pend_valid_d  = 1'b1;
            pend_target_d = fs.branch_target_i;
          end
        end else begin
          // the word fetched this cycle is always kept: it is the delay slot
          id_pc_d    = pc_q;
          id_inst_d  = fs.imem_inst_i;
          id_valid_d = 1'b1;
          id_adel_d  = (pc_q[1:0] != 2'b00);
          if (fs.branch_flag_i) begin
            pc_d         = fs.branch_target_i;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
    endcase
  end

  assign fs.imem_addr_o = pc_q;
  assign fs.ce_o        = (state_q == RUN);
  assign fs.id_pc_o     = id_pc_q;
  assign fs.id_inst_o   = id_inst_q;
  assign fs.id_valid_o  = id_valid_q;
  assign fs.id_adel_o   = id_adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the listed scenarios, then
// randomized control traffic against a cycle-level reference model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .fs  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // imem: word k holds 0x1000_0000 + k, address bits [1:0] ignored
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign bus.imem_inst_i = word_at(bus.imem_addr_o);

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        val;
    logic        adel;
  } vec_t;

  vec_t tbl[18];

  task automatic check_out(input string nm, input logic ce, input logic [31:0] addr,
                           input logic [31:0] ipc, input logic [31:0] inst,
                           input logic val, input logic adel);
    n_cmp++;
    if (bus.ce_o !== ce || bus.imem_addr_o !== addr || bus.id_pc_o !== ipc ||
        bus.id_inst_o !== inst || bus.id_valid_o !== val || bus.id_adel_o !== adel) begin
      n_bad++;
      $display("FAIL %s: got ce=%0b addr=%h id_pc=%h inst=%h v=%0b adel=%0b, want ce=%0b addr=%h id_pc=%h inst=%h v=%0b adel=%0b",
               nm, bus.ce_o, bus.imem_addr_o, bus.id_pc_o, bus.id_inst_o, bus.id_valid_o,
               bus.id_adel_o, ce, addr, ipc, inst, val, adel);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic b,
                       input logic [31:0] t, input logic [31:0] n);
    bus.stall_i         = s;
    bus.flush_i         = f;
    bus.branch_flag_i   = b;
    bus.branch_target_i = t;
    bus.new_pc_i        = n;
  endtask

  // Reference model: architectural view of the fetch stage
  logic        m_run;
  logic [31:0] m_pc, m_pend_tgt, m_ipc, m_inst;
  logic        m_pend, m_val, m_adel;

  task automatic model_reset();
    m_run = 1'b0; m_pc = RST_PC; m_pend = 1'b0; m_pend_tgt = 32'h0;
    m_ipc = 32'h0; m_inst = NOP; m_val = 1'b0; m_adel = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic b,
                            input logic [31:0] t, input logic [31:0] n);
    logic [31:0] fetched;
    fetched = word_at(m_pc);
    if (!m_run) begin
      m_run = 1'b1;
      m_ipc = 32'h0; m_inst = NOP; m_val = 1'b0; m_adel = 1'b0;
    end else if (f) begin
      m_pc = n; m_pend = 1'b0;
      m_ipc = 32'h0; m_inst = NOP; m_val = 1'b0; m_adel = 1'b0;
    end else if (s) begin
      if (b) begin m_pend = 1'b1; m_pend_tgt = t; end
    end else begin
      m_ipc = m_pc; m_inst = fetched; m_val = 1'b1; m_adel = (m_pc % 4) != 0;
      if (b)           m_pc = t;
      else if (m_pend) m_pc = m_pend_tgt;
      else             m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end
  endtask

  initial begin
    //            stall flush br  tgt           npc           ce  addr          id_pc         inst          v  adel
    tbl[0]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        NOP,          0, 0};
    tbl[1]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h4,        32'h0,        32'h1000_0000, 1, 0};
    tbl[2]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h8,        32'h4,        32'h1000_0001, 1, 0};
    tbl[3]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'hC,        32'h8,        32'h1000_0002, 1, 0};
    tbl[4]  = '{0, 0, 1, 32'h40,       32'h0,        1, 32'h40,       32'hC,        32'h1000_0003, 1, 0};
    tbl[5]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h44,       32'h40,       32'h1000_0010, 1, 0};
    tbl[6]  = '{1, 0, 0, 32'h0,        32'h0,        1, 32'h44,       32'h40,       32'h1000_0010, 1, 0};
    tbl[7]  = '{1, 0, 1, 32'h80,       32'h0,        1, 32'h44,       32'h40,       32'h1000_0010, 1, 0};
    tbl[8]  = '{1, 0, 0, 32'h0,        32'h0,        1, 32'h44,       32'h40,       32'h1000_0010, 1, 0};
    tbl[9]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h80,       32'h44,       32'h1000_0011, 1, 0};
    tbl[10] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h84,       32'h80,       32'h1000_0020, 1, 0};
    tbl[11] = '{1, 1, 1, 32'h300,      32'h180,      1, 32'h180,      32'h0,        NOP,          0, 0};
    tbl[12] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h184,      32'h180,      32'h1000_0060, 1, 0};
    tbl[13] = '{0, 0, 1, 32'h42,       32'h0,        1, 32'h42,       32'h184,      32'h1000_0061, 1, 0};
    tbl[14] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h46,       32'h42,       32'h1000_0010, 1, 1};
    tbl[15] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h4A,       32'h46,       32'h1000_0011, 1, 1};
    tbl[16] = '{0, 1, 0, 32'h0,        32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0,       NOP,          0, 0};
    tbl[17] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        32'hFFFF_FFFC, 32'h4FFF_FFFF, 1, 0};

    drive(0, 0, 0, 32'h0, 32'h0);
    #12;
    check_out("reset", 0, RST_PC, 32'h0, NOP, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].tgt, tbl[i].npc);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].ce, tbl[i].addr, tbl[i].ipc,
                tbl[i].inst, tbl[i].val, tbl[i].adel);
    end

    // asynchronous reset mid-cycle: outputs must drop without a clock edge
    drive(0, 0, 0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1 check_out("async_rst", 0, RST_PC, 32'h0, NOP, 0, 0);
    @(posedge clk);
    #1 check_out("rst_hold", 0, RST_PC, 32'h0, NOP, 0, 0);
    rst = 1'b1;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      logic s, f, b;
      logic [31:0] t, n;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 19) == 0);
      b = ($urandom_range(0, 4) == 0);
      t = {$urandom_range(0, 1023), 2'b00} & 32'h0000_0FFF;
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      n = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 1023), 2'b00};
      drive(s, f, b, t, n);
      @(posedge clk);
      model_step(s, f, b, t, n);
      #1;
      check_out("rand", m_run, m_pc, m_ipc, m_inst, m_val, m_adel);
      if ($urandom_range(0, 249) == 0) begin
        #1 rst = 1'b0;
        #1 check_out("rand_rst", 0, RST_PC, 32'h0, NOP, 0, 0);
        model_reset();
        #1 rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
